// File: rtl/led_breather_pkg.sv
// Shared definitions for the breathing-LED driver: phase encodings, clock default, width helper.
// Latency: n/a; no backpressure.
package led_breather_pkg;

  localparam int CLK_HZ_DEFAULT = 12_000_000;

  typedef enum logic [1:0] {
    PH_RISE    = 2'd0,
    PH_HOLD_HI = 2'd1,
    PH_FALL    = 2'd2,
    PH_HOLD_LO = 2'd3
  } phase_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_breather_if.sv
// LED-side bundle of the breather: enable in, PWM pad output and debug duty/phase out.
// Latency: n/a; no backpressure.
interface led_breather_if
  import led_breather_pkg::*;
#(
  parameter int PWM_BITS = 8
);

  logic                en;
  logic                LED;
  logic [PWM_BITS-1:0] duty;
  phase_t              phase;

  modport master (input en, output LED, duty, phase);
  modport slave  (output en, input LED, duty, phase);

endinterface

// File: rtl/led_breather_tick_prescaler.sv
// Divides clk down to a one-cycle tick every DIV cycles; clr restarts the count.
// Latency: tick is combinational from the counter; no backpressure.
module tick_prescaler
  import led_breather_pkg::*;
#(
  parameter int DIV = 24_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int          W    = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] presc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (clr || presc_cnt == LAST) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  assign tick = (presc_cnt == LAST);

endmodule

// File: rtl/led_breather.sv
// Breathing-LED PWM driver: duty ramps up, holds, ramps down, holds, forever.
// Latency: LED registered one cycle after the compare; no backpressure, en low restarts.
module led_breather
  import led_breather_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int STEP_HZ    = 500,
  parameter int PWM_BITS   = 8,
  parameter int HOLD_STEPS = 64
) (
  input  logic           clk,
  input  logic           rst,
  led_breather_if.master bus
);

  localparam int                  DIV       = CLK_HZ / STEP_HZ;
  localparam int                  HW        = cnt_width(HOLD_STEPS);
  localparam logic [PWM_BITS-1:0] MAXD      = '1;
  localparam logic [PWM_BITS-1:0] RISE_LAST = MAXD - 1'b1;
  localparam logic [PWM_BITS-1:0] FALL_LAST = PWM_BITS'(1);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_STEPS - 1);

  logic                step_tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_sh;
  logic [HW-1:0]       hold_cnt;
  phase_t              phase;
  logic                led;

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (~bus.en),
    .tick (step_tick)
  );

  // Duty is shadowed only at the period boundary so a period never changes shape.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_sh <= '0;
      led     <= 1'b0;
    end else if (!bus.en) begin
      pwm_cnt <= '0;
      duty_sh <= '0;
      led     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == MAXD) begin
        duty_sh <= duty;
      end
      led <= (pwm_cnt < duty_sh);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= PH_RISE;
      duty     <= '0;
      hold_cnt <= '0;
    end else if (!bus.en) begin
      phase    <= PH_RISE;
      duty     <= '0;
      hold_cnt <= '0;
    end else if (step_tick) begin
      case (phase)
        PH_RISE: begin
          duty <= duty + 1'b1;
          if (duty == RISE_LAST) begin
            phase    <= PH_HOLD_HI;
            hold_cnt <= '0;
          end
        end
        PH_HOLD_HI: begin
          if (hold_cnt == HOLD_LAST) begin
            phase <= PH_FALL;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        PH_FALL: begin
          duty <= duty - 1'b1;
          if (duty == FALL_LAST) begin
            phase    <= PH_HOLD_LO;
            hold_cnt <= '0;
          end
        end
        PH_HOLD_LO: begin
          if (hold_cnt == HOLD_LAST) begin
            phase <= PH_RISE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          phase <= PH_RISE;
        end
      endcase
    end
  end

  assign bus.LED   = led;
  assign bus.duty  = duty;
  assign bus.phase = phase;

endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather with DIV=10, MAXD=7, HOLD_STEPS=2.
// Edge e counts rising edges since the last reset release; outputs sampled 1 ns after each edge.
module tb_led_breather;
  import led_breather_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   e     = 0;

  led_breather_if #(.PWM_BITS(3)) bus ();

  led_breather #(
    .CLK_HZ     (1000),
    .STEP_HZ    (100),
    .PWM_BITS   (3),
    .HOLD_STEPS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Duty and phase after step tick count r (mod 18).
  int exp_duty  [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0};
  int exp_phase [18] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 2, 2, 2, 3, 3};

  task automatic edge_step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic step_to(input int target);
    while (e < target) edge_step();
  endtask

  task automatic restart();
    rst    = 1'b1;
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    e   = 0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    bus.en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.LED !== 1'b0) begin fails++; $display("FAIL reset_led got %0b exp 0", bus.LED); end
    tests++; if (bus.duty !== 3'd0) begin fails++; $display("FAIL reset_duty got %0d exp 0", bus.duty); end
    tests++; if (bus.phase !== 2'd0) begin fails++; $display("FAIL reset_phase got %0d exp 0", bus.phase); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    e   = 0;
    step_to(9);
    tests++; if (bus.duty !== 3'd0) begin fails++; $display("FAIL first_tick_early e=%0d got %0d exp 0", e, bus.duty); end
    step_to(10);
    tests++; if (bus.duty !== 3'd1) begin fails++; $display("FAIL first_tick e=%0d got %0d exp 1", e, bus.duty); end
    tests++; if (bus.phase !== 2'd0) begin fails++; $display("FAIL first_tick_phase got %0d exp 0", bus.phase); end
  endtask

  task automatic test_sequence();
    int r;
    restart();
    for (int k = 1; k <= 360; k++) begin
      edge_step();
      r = (e / 10) % 18;
      tests++;
      if (bus.duty !== 3'(exp_duty[r])) begin
        fails++; $display("FAIL seq_duty e=%0d got %0d exp %0d", e, bus.duty, exp_duty[r]);
      end
      tests++;
      if (bus.phase !== 2'(exp_phase[r])) begin
        fails++; $display("FAIL seq_phase e=%0d got %0d exp %0d", e, bus.phase, exp_phase[r]);
      end
    end
  endtask

  task automatic test_pwm_levels();
    int cs [4];
    int ds [4];
    cs = '{32, 72, 136, 168};
    ds = '{3, 7, 3, 0};
    restart();
    for (int i = 0; i < 4; i++) begin
      step_to(cs[i]);
      for (int k = 1; k <= 8; k++) begin
        edge_step();
        tests++;
        if (bus.LED !== (k <= ds[i])) begin
          fails++; $display("FAIL pwm_level d=%0d e=%0d got %0b exp %0b", ds[i], e, bus.LED, (k <= ds[i]));
        end
      end
    end
  endtask

  task automatic test_tick_mid_period();
    restart();
    step_to(16);
    for (int k = 1; k <= 8; k++) begin
      edge_step();
      if (e == 20) begin
        tests++; if (bus.duty !== 3'd2) begin fails++; $display("FAIL mid_tick_duty got %0d exp 2", bus.duty); end
      end
      tests++;
      if (bus.LED !== (k <= 1)) begin
        fails++; $display("FAIL mid_period_led e=%0d got %0b exp %0b", e, bus.LED, (k <= 1));
      end
    end
    for (int k = 1; k <= 8; k++) begin
      edge_step();
      tests++;
      if (bus.LED !== (k <= 2)) begin
        fails++; $display("FAIL next_period_led e=%0d got %0b exp %0b", e, bus.LED, (k <= 2));
      end
    end
    step_to(40);
    tests++; if (bus.duty !== 3'd4) begin fails++; $display("FAIL coincide_duty got %0d exp 4", bus.duty); end
    for (int k = 1; k <= 8; k++) begin
      edge_step();
      tests++;
      if (bus.LED !== (k <= 3)) begin
        fails++; $display("FAIL coincide_led e=%0d got %0b exp %0b", e, bus.LED, (k <= 3));
      end
    end
  endtask

  task automatic test_en_drop();
    restart();
    step_to(123);
    tests++; if (bus.phase !== 2'd2) begin fails++; $display("FAIL pre_drop_phase got %0d exp 2", bus.phase); end
    tests++; if (bus.duty !== 3'd4) begin fails++; $display("FAIL pre_drop_duty got %0d exp 4", bus.duty); end
    tests++; if (bus.LED !== 1'b1) begin fails++; $display("FAIL pre_drop_led got %0b exp 1", bus.LED); end
    bus.en = 1'b0;
    edge_step();
    bus.en = 1'b1;
    tests++; if (bus.LED !== 1'b0) begin fails++; $display("FAIL drop_led got %0b exp 0", bus.LED); end
    tests++; if (bus.duty !== 3'd0) begin fails++; $display("FAIL drop_duty got %0d exp 0", bus.duty); end
    tests++; if (bus.phase !== 2'd0) begin fails++; $display("FAIL drop_phase got %0d exp 0", bus.phase); end
    step_to(133);
    tests++; if (bus.duty !== 3'd0) begin fails++; $display("FAIL resume_early got %0d exp 0", bus.duty); end
    step_to(134);
    tests++; if (bus.duty !== 3'd1) begin fails++; $display("FAIL resume_tick got %0d exp 1", bus.duty); end
  endtask

  task automatic test_async_rst();
    restart();
    step_to(75);
    tests++; if (bus.LED !== 1'b1) begin fails++; $display("FAIL hold_led got %0b exp 1", bus.LED); end
    tests++; if (bus.phase !== 2'd1) begin fails++; $display("FAIL hold_phase got %0d exp 1", bus.phase); end
    #3;
    rst = 1'b1;
    #1;
    tests++; if (bus.LED !== 1'b0) begin fails++; $display("FAIL async_led got %0b exp 0", bus.LED); end
    tests++; if (bus.duty !== 3'd0) begin fails++; $display("FAIL async_duty got %0d exp 0", bus.duty); end
    tests++; if (bus.phase !== 2'd0) begin fails++; $display("FAIL async_phase got %0d exp 0", bus.phase); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    e   = 0;
    step_to(10);
    tests++; if (bus.duty !== 3'd1) begin fails++; $display("FAIL rerun_duty got %0d exp 1", bus.duty); end
    step_to(73);
    tests++; if (bus.LED !== 1'b1) begin fails++; $display("FAIL rerun_led got %0b exp 1", bus.LED); end
    tests++; if (bus.phase !== 2'd1) begin fails++; $display("FAIL rerun_phase got %0d exp 1", bus.phase); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    bus.en = 1'b0;
    test_reset();
    test_sequence();
    test_pwm_levels();
    test_tick_mid_period();
    test_en_drop();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_breather.md
Name: led_breather

Overview:
- Breathing-LED driver that sits directly upstream of the board LED pin in top; its LED output connects straight to the pad.
- Produces a PWM waveform whose duty ramps up, holds, ramps down and holds, repeating continuously.
- Runs from the 12 MHz board clock and replaces the plain blink counter as the LED source.

Parameters:
- CLK_HZ, 12_000_000, input clock frequency in Hz.
- STEP_HZ, 500, rate of duty/hold steps in Hz; DIV = CLK_HZ/STEP_HZ (integer division) must be >= 2.
- PWM_BITS, 8, PWM counter and duty width; MAXD = 2^PWM_BITS - 1.
- HOLD_STEPS, 64, number of step ticks spent in each hold phase; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  enable; low forces the idle/restart condition (synchronous).
- LED  output  1  PWM output to the pad, registered.
- duty  output  PWM_BITS  current ramp duty value, for debug.
- phase  output  2  FSM state: 0 RISE, 1 HOLD_HI, 2 FALL, 3 HOLD_LO.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values, all zero: LED=0, duty=0, phase=RISE, presc_cnt=0, pwm_cnt=0, hold_cnt=0, duty_sh=0.
- Prescaler:
  - presc_cnt counts 0..DIV-1 and wraps to 0.
  - step_tick is a one-cycle pulse in the cycle where presc_cnt==DIV-1.
- PWM counter:
  - pwm_cnt is free-running, PWM_BITS wide, wrapping MAXD->0.
  - duty_sh <= duty in the cycle where pwm_cnt==MAXD, so a new duty takes effect from the next period. Duty never changes mid-period.
- Output:
  - LED <= en & (pwm_cnt < duty_sh), registered; one cycle of latency after the compare.
  - duty_sh=0: LED constantly 0.
  - duty_sh=MAXD: LED high for MAXD of every 2^PWM_BITS cycles.
- FSM, advancing only on step_tick:
  - RISE: duty++. When duty becomes MAXD, go to HOLD_HI and set hold_cnt=0.
  - HOLD_HI: hold_cnt++. When hold_cnt==HOLD_STEPS-1, go to FALL.
  - FALL: duty--. When duty becomes 0, go to HOLD_LO and set hold_cnt=0.
  - HOLD_LO: hold_cnt++. When hold_cnt==HOLD_STEPS-1, go to RISE.
- Arithmetic limits: duty never wraps; saturation is implied by the state changes. hold_cnt width is clog2(HOLD_STEPS), minimum 1.
- Full cycle length = (2*MAXD + 2*HOLD_STEPS) step ticks.
- en low, synchronous and highest priority after rst:
  - State, duty, presc_cnt, pwm_cnt, hold_cnt and duty_sh go to their reset values.
  - LED=0 from the next edge.
- en rising: the sequence restarts at RISE with duty=0, and the first step_tick comes DIV cycles later.
- step_tick coinciding with pwm_cnt==MAXD: duty_sh captures the pre-update duty value.
- rst mid-operation: all outputs drop immediately, without waiting for a clock edge.

Decomposition:
- Shared include/package led_defs holds:
  - phase encodings PH_RISE, PH_HOLD_HI, PH_FALL, PH_HOLD_LO;
  - the CLK_HZ default of 12_000_000.
- One sub-module, tick_prescaler:
  - parameter DIV; ports clk, rst, clr, tick;
  - instantiated once, with clr driven by ~en.
- PWM compare and FSM stay in led_breather.

Test Plan (bench parameters: CLK_HZ=1000, STEP_HZ=100 so DIV=10; PWM_BITS=3 so MAXD=7; HOLD_STEPS=2):
1. Assert rst for 3 cycles, then release with en=1 -> during rst LED=0, duty=0, phase=0; first step_tick at cycle 9 after release; duty=1 after it.
2. Run a full sequence -> phase sequence RISE, HOLD_HI, FALL, HOLD_LO; duty peaks at 7 and returns to 0; total period 18 ticks = 180 cycles; repeats identically.
3. With duty_sh=3 -> LED high for exactly 3 of every 8 cycles, delayed one cycle from pwm_cnt 0..2. With duty_sh=7 -> 7 of 8 cycles. With duty_sh=0 -> LED stays 0.
4. Step tick at pwm_cnt=2 -> duty_sh does not change until after pwm_cnt==7; no LED glitch inside the current period.
5. Drop en for 1 cycle during FALL with duty=4 -> next edge gives LED=0, duty=0, phase=RISE; after en returns, the first step comes 10 cycles later.
6. Assert rst asynchronously between clock edges while in HOLD_HI with LED high -> LED and duty are 0 immediately, before the next edge; the sequence restarts cleanly after release.
